// File: rtl/sigma_delta_decimator.sv
// Second-order CIC (sinc2) decimator for a 1-bit sigma-delta stream.
// Decimates by 2^DEC_LOG2 and emits signed OUT_WIDTH-bit samples with a strobe.
module sigma_delta_decimator #(
    parameter int DEC_LOG2  = 6,
    parameter int OUT_WIDTH = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        sdIn,
    output logic signed [OUT_WIDTH-1:0] out,
    output logic                        outValid
);

    localparam int ACC_W = 2 * DEC_LOG2 + 1;
    localparam int SH    = 2 * DEC_LOG2 - OUT_WIDTH;

    typedef logic [ACC_W-1:0]    acc_t;
    typedef logic [DEC_LOG2-1:0] cnt_t;

    localparam acc_t HALF  = acc_t'(1) << (2 * DEC_LOG2 - 1);
    localparam acc_t S_MAX = HALF - acc_t'(1);

    acc_t i1_q, i1_d;
    acc_t i2_q, i2_d;
    acc_t snap_q, snap_d;
    acc_t snapd_q, snapd_d;
    acc_t c1_q, c1_d;
    acc_t c1d_q, c1d_d;
    cnt_t cnt_q, cnt_d;
    logic s1v_q, s1v_d;
    logic s2v_q, s2v_d;
    logic valid_q, valid_d;
    logic [1:0] prime_q, prime_d;
    logic signed [OUT_WIDTH-1:0] out_q, out_d;

    acc_t c2;
    logic signed [ACC_W-1:0] s_sat;
    logic dec_edge;

    always_comb begin
        i1_d    = i1_q;
        i2_d    = i2_q;
        snap_d  = snap_q;
        snapd_d = snapd_q;
        c1_d    = c1_q;
        c1d_d   = c1d_q;
        cnt_d   = cnt_q;
        prime_d = prime_q;
        out_d   = out_q;
        valid_d = 1'b0;

        // raw never exceeds R^2, so its top bit set means exactly R^2
        c2       = c1_q - c1d_q;
        s_sat    = c2[ACC_W-1] ? S_MAX : (c2 - HALF);
        dec_edge = en && (cnt_q == '1);

        if (en) begin
            i1_d  = i1_q + acc_t'(sdIn);
            i2_d  = i2_q + i1_q;
            cnt_d = cnt_q + cnt_t'(1);
        end

        s1v_d = dec_edge;
        if (dec_edge) begin
            snap_d = i2_q + i1_q;
        end

        s2v_d = s1v_q;
        if (s1v_q) begin
            c1_d    = snap_q - snapd_q;
            snapd_d = snap_q;
        end

        if (s2v_q) begin
            c1d_d = c1_q;
            if (prime_q == 2'd2) begin
                valid_d = 1'b1;
                out_d   = OUT_WIDTH'(s_sat >>> SH);
            end else begin
                prime_d = prime_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i1_q    <= '0;
            i2_q    <= '0;
            snap_q  <= '0;
            snapd_q <= '0;
            c1_q    <= '0;
            c1d_q   <= '0;
            cnt_q   <= '0;
            s1v_q   <= 1'b0;
            s2v_q   <= 1'b0;
            valid_q <= 1'b0;
            prime_q <= '0;
            out_q   <= '0;
        end else begin
            i1_q    <= i1_d;
            i2_q    <= i2_d;
            snap_q  <= snap_d;
            snapd_q <= snapd_d;
            c1_q    <= c1_d;
            c1d_q   <= c1d_d;
            cnt_q   <= cnt_d;
            s1v_q   <= s1v_d;
            s2v_q   <= s2v_d;
            valid_q <= valid_d;
            prime_q <= prime_d;
            out_q   <= out_d;
        end
    end

    assign out      = out_q;
    assign outValid = valid_q;

endmodule

// File: tb/tb_sigma_delta_decimator.sv
// Bench for sigma_delta_decimator: two configurations driven in parallel,
// checked each cycle against a sliding-window-count model plus literals.
module tb_sigma_delta_decimator;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic en   = 1'b0;
    logic sdIn = 1'b0;

    logic signed [11:0] out0;
    logic               v0;
    logic signed [5:0]  out1;
    logic               v1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sigma_delta_decimator #(.DEC_LOG2(6), .OUT_WIDTH(12)) dut0 (
        .clk(clk), .rst(rst), .en(en), .sdIn(sdIn),
        .out(out0), .outValid(v0)
    );

    sigma_delta_decimator #(.DEC_LOG2(4), .OUT_WIDTH(6)) dut1 (
        .clk(clk), .rst(rst), .en(en), .sdIn(sdIn),
        .out(out1), .outValid(v1)
    );

    // model state, one lane per instance
    int   dl [2] = '{6, 4};
    int   ow [2] = '{12, 6};
    int   pre [2][0:20000];
    int   ns [2];
    int   pend_due [2];
    int   pend_val [2];
    int   pend_idx [2];
    logic exp_v [2];
    int   exp_o [2];
    int   edge_no = 0;
    logic started = 1'b0;

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Result n = sum of the ones-counts of the R sliding windows ending
    // at samples (n-1)R .. nR-1, offset to signed, clipped and scaled.
    function automatic int model_out(input int l, input int n);
        int r, half, raw, sv;
        r    = 1 << dl[l];
        half = 1 << (2 * dl[l] - 1);
        raw  = 0;
        for (int s = (n - 1) * r; s < n * r; s++)
            raw += pre[l][s] - pre[l][s - r];
        sv = raw - half;
        if (sv > half - 1) sv = half - 1;
        return sv >>> (2 * dl[l] - ow[l]);
    endfunction

    always @(posedge clk) begin
        edge_no++;
        for (int l = 0; l < 2; l++) begin
            exp_v[l] = 1'b0;
            if (rst) begin
                ns[l]       = 0;
                pre[l][0]   = 0;
                pend_due[l] = -1;
                exp_o[l]    = 0;
            end else begin
                if (pend_due[l] == edge_no) begin
                    pend_due[l] = -1;
                    if (pend_idx[l] >= 3) begin
                        exp_v[l] = 1'b1;
                        exp_o[l] = pend_val[l];
                    end
                end
                if (en && ns[l] < 20000) begin
                    ns[l]++;
                    pre[l][ns[l]] = pre[l][ns[l] - 1] + int'(sdIn);
                    if (ns[l] % (1 << dl[l]) == 0) begin
                        pend_due[l] = edge_no + 2;
                        pend_idx[l] = ns[l] / (1 << dl[l]);
                        pend_val[l] = (pend_idx[l] >= 3) ?
                                      model_out(l, pend_idx[l]) : 0;
                    end
                end
            end
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("valid0", int'(v0), int'(exp_v[0]));
            chk("out0", int'(out0), exp_o[0]);
            chk("valid1", int'(v1), int'(exp_v[1]));
            chk("out1", int'(out1), exp_o[1]);
        end
    end

    task automatic apply_reset(input int cyc);
        rst  = 1'b1;
        en   = 1'b0;
        sdIn = 1'b0;
        repeat (cyc) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called right after rst falls: all-ones stream, first pulse timing,
    // pulse spacing and full-scale value.
    task automatic run_ones_check(input string tag);
        int first;
        int pulses;
        first  = -1;
        pulses = 0;
        en     = 1'b1;
        sdIn   = 1'b1;
        for (int i = 1; i <= 834; i++) begin
            @(negedge clk);
            if (v0) begin
                if (first < 0) first = i;
                else pulses++;
            end
        end
        chk({tag, "_first_valid_edge"}, first, 3 * 64 + 2);
        chk({tag, "_pulses"}, pulses, 10);
        chk({tag, "_out0_full"}, int'(out0), 2047);
        chk({tag, "_out1_full"}, int'(out1), 31);
    endtask

    initial begin
        int   acc;
        int   dev;
        int   pulses;
        int   encnt;
        int   dec_edge;
        logic e;
        logic b;

        // 1: reset then continuous ones
        apply_reset(2);
        run_ones_check("t1");

        // 2: all zeros, then alternating
        sdIn = 1'b0;
        repeat (400) @(negedge clk);
        chk("t2_out0_zero", int'(out0), -2048);
        chk("t2_out1_zero", int'(out1), -32);
        for (int i = 0; i < 400; i++) begin
            sdIn = ~sdIn;
            @(negedge clk);
        end
        chk("t2_out0_alt", int'(out0), 0);
        chk("t2_out1_alt", int'(out1), 0);

        // 3: first-order modulator stream, +512 then -1000
        apply_reset(1);
        acc = 0;
        for (int i = 0; i < 1000; i++) begin
            b    = (acc >= 0);
            en   = 1'b1;
            sdIn = b;
            acc  = acc + 512 - (b ? 2048 : -2048);
            @(negedge clk);
        end
        chk("t3_out0_p512", int'(out0), 512);
        chk("t3_out1_p512", int'(out1), 8);
        for (int i = 0; i < 1000; i++) begin
            b    = (acc >= 0);
            sdIn = b;
            acc  = acc - 1000 - (b ? 2048 : -2048);
            @(negedge clk);
        end
        dev = int'(out0) + 1000;
        chk("t3_out0_m1000_dev", (dev >= -4 && dev <= 4) ? 0 : dev, 0);

        // 4: sparse enable with ones
        apply_reset(1);
        pulses   = 0;
        encnt    = 0;
        dec_edge = -100;
        for (int i = 1; i <= 2000; i++) begin
            e    = ($urandom_range(0, 99) < 30);
            en   = e;
            sdIn = 1'b1;
            @(negedge clk);
            if (v0) begin
                pulses++;
                chk("t4_latency", i - dec_edge, 2);
                chk("t4_out0", int'(out0), 2047);
            end
            if (e) begin
                encnt++;
                if (encnt % 64 == 0) dec_edge = i;
            end
        end
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (v0) pulses++;
        end
        chk("t4_pulses", pulses, encnt / 64 - 2);

        // 5: small configuration over long runs
        apply_reset(1);
        en   = 1'b1;
        sdIn = 1'b1;
        repeat (5000) @(negedge clk);
        chk("t5_out1_ones", int'(out1), 31);
        sdIn = 1'b0;
        repeat (5000) @(negedge clk);
        chk("t5_out1_zeros", int'(out1), -32);

        // 6: reset while result 4 sits between k and k+2
        apply_reset(1);
        en   = 1'b1;
        sdIn = 1'b1;
        repeat (256) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_valid", int'(v0), 0);
        chk("t6_rst_out", int'(out0), 0);
        rst = 1'b0;
        run_ones_check("t6");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
